reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 106 ++++++++++
 tb/tb_reg_writeback.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-bank writeback queue: merges ALU and load results into one write port, mem has priority.
// Optional forwarding of queued results is compiled in with REG_WRITEBACK_FORWARD_EN.
module reg_writeback #(
  parameter int BITS     = 8,
  parameter int REG_SIZE = 4,
  parameter int DEPTH    = 2,
  localparam int AW      = $clog2(REG_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [AW-1:0]       alu_addr,
  input  logic [BITS-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [AW-1:0]       mem_addr,
  input  logic [BITS-1:0]     mem_data,
  output logic                mem_ready,
  output logic                write_enable,
  output logic [AW-1:0]       write_address,
  output logic [BITS-1:0]     write_data,
  output logic [REG_SIZE-1:0] pending,
  input  logic [AW-1:0]       fwd_addr,
  output logic                fwd_hit,
  output logic [BITS-1:0]     fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]   q_addr [DEPTH];
  logic [BITS-1:0] q_data [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, push, pop, push_mem, push_alu;
  logic [AW-1:0]   push_addr;
  logic [BITS-1:0] push_data;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Readies are gated by reset so nothing is accepted while rst_n is low.
  assign mem_ready = rst_n && !full;
  assign alu_ready = rst_n && !full && !mem_valid;

  assign push_mem  = mem_valid && mem_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_mem || push_alu;
  assign pop       = !empty;
  assign push_addr = push_mem ? mem_addr : alu_addr;
  assign push_data = push_mem ? mem_data : alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= push_addr;
      q_data[wr_ptr] <= push_data;
    end
  end

  assign write_enable  = !empty;
  assign write_address = empty ? '0 : q_addr[rd_ptr];
  assign write_data    = empty ? '0 : q_data[rd_ptr];

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) pending[q_addr[rd_ptr + PW'(k)]] = 1'b1;
    end
  end

`ifdef REG_WRITEBACK_FORWARD_EN
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && q_addr[rd_ptr + PW'(k)] == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[rd_ptr + PW'(k)];
      end
    end
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^fwd_addr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a queue-based reference model checked every cycle.
module tb_reg_writeback;
  localparam int BITS = 8, REG_SIZE = 4, DEPTH = 2, AW = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0, mem_addr = '0, fwd_addr = '0;
  logic [BITS-1:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, write_enable, fwd_hit;
  logic [AW-1:0] write_address;
  logic [BITS-1:0] write_data, fwd_data;
  logic [REG_SIZE-1:0] pending;

  int n_vec = 0, n_err = 0;

  typedef struct packed { logic [AW-1:0] a; logic [BITS-1:0] d; } ent_t;
  ent_t model_q [$];
  ent_t wlog [$];

  reg_writeback #(.BITS(BITS), .REG_SIZE(REG_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .pending(pending), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; head is written each edge, accepted request appended.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_q.delete();
    else begin
      bit acc_mem, acc_alu;
      acc_mem = mem_valid && model_q.size() < DEPTH;
      acc_alu = alu_valid && !mem_valid && model_q.size() < DEPTH;
      if (model_q.size() > 0) void'(model_q.pop_front());
      if (acc_mem) model_q.push_back({mem_addr, mem_data});
      else if (acc_alu) model_q.push_back({alu_addr, alu_data});
    end
  end

  // Per-cycle compare, sampled mid low phase after inputs have settled.
  always @(negedge clk) begin
    #2;
    begin
      logic [REG_SIZE-1:0] e_pend;
      logic e_hit;
      logic [BITS-1:0] e_fd;
      logic e_full;
      e_pend = '0; e_hit = 1'b0; e_fd = '0;
      foreach (model_q[i]) begin
        e_pend[model_q[i].a] = 1'b1;
`ifdef REG_WRITEBACK_FORWARD_EN
        if (model_q[i].a == fwd_addr) begin e_hit = 1'b1; e_fd = model_q[i].d; end
`endif
      end
      e_full = (model_q.size() >= DEPTH);
      chk("m_we", write_enable, model_q.size() != 0);
      chk("m_waddr", write_address, model_q.size() != 0 ? model_q[0].a : '0);
      chk("m_wdata", write_data, model_q.size() != 0 ? model_q[0].d : '0);
      chk("m_pending", pending, e_pend);
      chk("m_mem_rdy", mem_ready, rst_n && !e_full);
      chk("m_alu_rdy", alu_ready, rst_n && !e_full && !mem_valid);
      chk("m_fwd_hit", fwd_hit, e_hit);
      chk("m_fwd_data", fwd_data, e_fd);
      if (rst_n && write_enable) wlog.push_back({write_address, write_data});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    settle();
    chk("rst_we", write_enable, 1'b0);
    chk("rst_mem_rdy", mem_ready, 1'b0);
    chk("rst_alu_rdy", alu_ready, 1'b0);
    chk("rst_pending", pending, 4'b0000);
    step(); rst_n = 1'b1;
    settle();
    chk("rel_mem_rdy", mem_ready, 1'b1);

    // Single write: 2/0x5A
    step(); alu_valid = 1; alu_addr = 2; alu_data = 8'h5A;
    settle(); chk("sw_alu_rdy", alu_ready, 1'b1);
    step(); alu_valid = 0;
    settle();
    chk("sw_we", write_enable, 1'b1);
    chk("sw_addr", write_address, 2);
    chk("sw_data", write_data, 8'h5A);
    chk("sw_pend", pending, 4'b0100);
    step(); settle();
    chk("sw_we_after", write_enable, 1'b0);
    chk("sw_pend_after", pending, 4'b0000);

    // Priority: mem 3/0x33 beats alu 1/0x11
    step(); alu_valid = 1; alu_addr = 1; alu_data = 8'h11;
    mem_valid = 1; mem_addr = 3; mem_data = 8'h33;
    settle();
    chk("pr_alu_rdy", alu_ready, 1'b0);
    chk("pr_mem_rdy", mem_ready, 1'b1);
    step(); mem_valid = 0;
    settle();
    chk("pr_alu_rdy2", alu_ready, 1'b1);
    chk("pr_w1_addr", write_address, 3);
    chk("pr_w1_data", write_data, 8'h33);
    step(); alu_valid = 0;
    settle();
    chk("pr_w2_addr", write_address, 1);
    chk("pr_w2_data", write_data, 8'h11);
    chk("pr_w2_pend", pending, 4'b0010);
    step(); settle();
    chk("pr_empty", write_enable, 1'b0);

    // Continuous mem pushes across several pointer wraps
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      step(); mem_valid = 1; mem_addr = AW'(i % 4); mem_data = 8'h80 + 8'(i);
      settle(); chk("ct_mem_rdy", mem_ready, 1'b1);
    end
    step(); mem_valid = 0;
    repeat (2) step();
    chk("ct_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("ct_w_addr", wlog[i].a, i % 4);
      chk("ct_w_data", wlog[i].d, 8'h80 + i);
    end

    // Forwarding: 2/0x10 then 2/0x20 queued back to back
    step(); fwd_addr = 2; alu_valid = 1; alu_addr = 2; alu_data = 8'h10;
    step(); alu_data = 8'h20;
    settle();
`ifdef REG_WRITEBACK_FORWARD_EN
    chk("fw_hit1", fwd_hit, 1'b1);
    chk("fw_data1", fwd_data, 8'h10);
`else
    chk("fw_hit1", fwd_hit, 1'b0);
`endif
    step(); alu_valid = 0;
    settle();
`ifdef REG_WRITEBACK_FORWARD_EN
    chk("fw_hit2", fwd_hit, 1'b1);
    chk("fw_data2", fwd_data, 8'h20);
`else
    chk("fw_hit2", fwd_hit, 1'b0);
    chk("fw_data2", fwd_data, 8'h00);
`endif
    chk("fw_pend", pending, 4'b0100);
    step(); settle();
    chk("fw_hit_empty", fwd_hit, 1'b0);

    // Reset mid-operation
    step(); mem_valid = 1; mem_addr = 1; mem_data = 8'hA1;
    step(); mem_addr = 2; mem_data = 8'hA2;
    settle();
    chk("rm_we_before", write_enable, 1'b1);
    rst_n = 1'b0; #1;
    chk("rm_we", write_enable, 1'b0);
    chk("rm_addr", write_address, 0);
    chk("rm_data", write_data, 0);
    chk("rm_pend", pending, 4'b0000);
    chk("rm_mem_rdy", mem_ready, 1'b0);
    chk("rm_alu_rdy", alu_ready, 1'b0);
    step(); settle();
    chk("rm_dropped", write_enable, 1'b0);
    step(); rst_n = 1'b1; mem_valid = 0;
    settle();
    chk("rm_rel_rdy", mem_ready, 1'b1);
    step(); settle();
    chk("rm_idle", write_enable, 1'b0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
